// File: rtl/mips_debug_unit_if.sv
// mips_debug_unit_if
//   Bundles the UART-side handshake and the pipeline debug buses of the
//   debug unit.
//   master : the debug unit (drives tx/step/debug index, reads pipeline data)
//   slave  : the environment (uart_rx/uart_tx pair and the PIPELINE block)
//   Signals:
//     i_rx_data/i_rx_done          received byte + 1-cycle valid pulse
//     i_tx_done                    uart_tx finished current byte
//     o_tx_start/o_tx_data         launch pulse + byte to transmit
//     o_step                       pipeline advance enable
//     o_debug_mips_register_number register read index
//     o_debug_address              data-memory byte address for debug read
//     i_mips_pc/alu_result         pipeline state read back
//     i_mips_register_data         register[index], combinational
//     i_mips_data_memory           mem[address], combinational
//     o_busy                       dump in progress
interface mips_debug_unit_if #(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_step;
  logic [4:0]         o_debug_mips_register_number;
  logic [NB-1:0]      o_debug_address;
  logic [NB-1:0]      i_mips_pc;
  logic [NB-1:0]      i_mips_alu_result;
  logic [NB-1:0]      i_mips_register_data;
  logic [NB-1:0]      i_mips_data_memory;
  logic               o_busy;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done,
    input  i_mips_pc, i_mips_alu_result, i_mips_register_data, i_mips_data_memory,
    output o_tx_start, o_tx_data, o_step,
    output o_debug_mips_register_number, o_debug_address, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done,
    output i_mips_pc, i_mips_alu_result, i_mips_register_data, i_mips_data_memory,
    input  o_tx_start, o_tx_data, o_step,
    input  o_debug_mips_register_number, o_debug_address, o_busy
  );
endinterface

// File: rtl/mips_debug_unit.sv
// mips_debug_unit
//   Host-side controller of the pipeline debug interface. Decodes command
//   bytes ('S' step+dump, 'C' run, 'P' pause+dump, 'D' dump) from the UART
//   receiver, drives the pipeline step enable and debug read index/address,
//   and serializes PC, ALU result, R0..R31 and TAM_DATA_MEMORY memory words
//   (LSB byte first) to the UART transmitter.
//   Ports:
//     i_clk   system clock, rising edge
//     i_reset asynchronous, active-low reset
//     dbg     UART handshake + pipeline debug buses (master side)
module mips_debug_unit #(
  parameter int NB              = 32,
  parameter int TAM_DATA_MEMORY = 16,
  parameter int NB_BYTE         = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  mips_debug_unit_if.master  dbg
);

  localparam int NWORDS = 34 + TAM_DATA_MEMORY;
  localparam int WW     = $clog2(NWORDS);
  localparam int BPW    = NB / NB_BYTE;
  localparam int BW     = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [NB_BYTE-1:0] CMD_S = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_C = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] CMD_P = NB_BYTE'(8'h50);
  localparam logic [NB_BYTE-1:0] CMD_D = NB_BYTE'(8'h44);

  localparam logic [WW-1:0] W_REG0 = WW'(2);
  localparam logic [WW-1:0] W_MEM0 = WW'(34);
  localparam logic [WW-1:0] W_LAST = WW'(NWORDS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BPW - 1);

  typedef enum logic [2:0] {
    IDLE, STEP, RUN, SETTLE, LOAD, SEND, WAIT_TX
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   word_q, word_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [NB-1:0]   shreg_q, shreg_d;
  logic [4:0]      regnum_q, regnum_d;
  logic [NB-1:0]   addr_q, addr_d;
  logic [WW-1:0]   word_nxt;
  logic [NB-1:0]   word_sel;

  assign word_nxt = word_q + 1'b1;

  // Word source for the frame slot currently addressed.
  always_comb begin
    word_sel = dbg.i_mips_data_memory;
    if (word_q == '0)              word_sel = dbg.i_mips_pc;
    else if (word_q == WW'(1))     word_sel = dbg.i_mips_alu_result;
    else if (word_q < W_MEM0)      word_sel = dbg.i_mips_register_data;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      byte_q   <= '0;
      shreg_q  <= '0;
      regnum_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      byte_q   <= byte_d;
      shreg_q  <= shreg_d;
      regnum_q <= regnum_d;
      addr_q   <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    byte_d   = byte_q;
    shreg_d  = shreg_q;
    regnum_d = regnum_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (dbg.i_rx_done) begin
          if (dbg.i_rx_data == CMD_S)      state_d = STEP;
          else if (dbg.i_rx_data == CMD_C) state_d = RUN;
          else if (dbg.i_rx_data == CMD_D) state_d = SETTLE;
        end
      end
      STEP:   state_d = SETTLE;
      RUN: begin
        if (dbg.i_rx_done && dbg.i_rx_data == CMD_P) state_d = SETTLE;
      end
      // Index/address were updated last cycle; give the combinational
      // register-file/memory reads a cycle before capturing.
      SETTLE: state_d = LOAD;
      LOAD: begin
        shreg_d = word_sel;
        state_d = SEND;
      end
      SEND:   state_d = WAIT_TX;
      WAIT_TX: begin
        if (dbg.i_tx_done) begin
          if (byte_q != B_LAST) begin
            byte_d  = byte_q + 1'b1;
            shreg_d = shreg_q >> NB_BYTE;
            state_d = SEND;
          end else if (word_q != W_LAST) begin
            word_d  = word_nxt;
            byte_d  = '0;
            if (word_nxt >= W_MEM0)
              addr_d = NB'(word_nxt - W_MEM0) << 2;
            else if (word_nxt >= W_REG0)
              regnum_d = 5'(word_nxt - W_REG0);
            state_d = SETTLE;
          end else begin
            // End of frame: park counters and debug index at 0.
            word_d   = '0;
            byte_d   = '0;
            regnum_d = '0;
            addr_d   = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg.o_tx_start                   = (state_q == SEND);
  assign dbg.o_tx_data                    = shreg_q[NB_BYTE-1:0];
  assign dbg.o_step                       = (state_q == STEP) || (state_q == RUN);
  assign dbg.o_busy                       = (state_q != IDLE) && (state_q != RUN);
  assign dbg.o_debug_mips_register_number = regnum_q;
  assign dbg.o_debug_address              = addr_q;

endmodule

// File: tb/tb_mips_debug_unit.sv
module tb_mips_debug_unit;
  localparam int NB = 32, TAM = 16, NBY = 8;
  localparam int NWORDS = 34 + TAM, FBYTES = 4 * NWORDS;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  mips_debug_unit_if #(.NB(NB), .NB_BYTE(NBY)) dbg();
  mips_debug_unit #(.NB(NB), .TAM_DATA_MEMORY(TAM), .NB_BYTE(NBY)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .dbg(dbg)
  );

  int checks = 0, errors = 0;

  // Pipeline stub: PC advances by 4 per step; the J 2 at instruction 6
  // takes effect once PC reaches 32, redirecting to 8.
  logic [31:0] pc_r;
  logic [31:0] regs [32];
  logic [31:0] mem  [TAM];
  always @(posedge i_clk or negedge i_reset)
    if (!i_reset) pc_r <= '0;
    else if (dbg.o_step) pc_r <= (pc_r == 32) ? 32'd8 : pc_r + 32'd4;

  assign dbg.i_mips_pc            = pc_r;
  assign dbg.i_mips_alu_result    = pc_r * 3 + 32'h100;
  assign dbg.i_mips_register_data = regs[dbg.o_debug_mips_register_number];
  assign dbg.i_mips_data_memory   = mem[dbg.o_debug_address[5:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // UART transmitter stand-in: done pulse a couple of cycles after start.
  initial begin
    dbg.i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (dbg.o_tx_start) begin
        repeat (2) @(posedge i_clk);
        #1 dbg.i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 dbg.i_tx_done = 1'b0;
      end
    end
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Frame model: at the first byte of a frame the expected 200-byte frame is
  // built from the (frozen) pipeline state; every transmitted byte is then
  // checked against it along with the debug index/address it came from.
  logic [7:0]  exp_q[$];
  logic [7:0]  rxf     [FBYTES];
  logic [31:0] addr_at [FBYTES];
  int frame_pos = 0, frames_done = 0, step_cnt = 0, first_tx_cyc = 0;
  bit outstanding = 0;

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        exp_q.delete();
        frame_pos   = 0;
        outstanding = 0;
      end else begin
        if (dbg.i_tx_done) outstanding = 0;
        if (dbg.o_step) step_cnt++;
        if (dbg.o_tx_start || outstanding) chk("step_frozen", {31'd0, dbg.o_step}, 32'd0);
        if (dbg.o_tx_start) begin
          int w;
          chk("tx_overlap", {31'd0, outstanding}, 32'd0);
          outstanding = 1;
          if (frame_pos == 0) begin
            exp_q.delete();
            push_word(pc_r);
            push_word(pc_r * 3 + 32'h100);
            for (int r = 0; r < 32; r++) push_word(regs[r]);
            for (int m = 0; m < TAM; m++) push_word(mem[m]);
            first_tx_cyc = cyc;
          end
          w = frame_pos / 4;
          chk("tx_byte", {24'd0, dbg.o_tx_data}, {24'd0, exp_q.pop_front()});
          if (w >= 2 && w < 34)
            chk("reg_index", {27'd0, dbg.o_debug_mips_register_number}, 32'(w - 2));
          else if (w >= 34)
            chk("mem_addr", dbg.o_debug_address, 32'((w - 34) * 4));
          rxf[frame_pos]     = dbg.o_tx_data;
          addr_at[frame_pos] = dbg.o_debug_address;
          frame_pos++;
          if (frame_pos == FBYTES) begin
            frames_done++;
            frame_pos = 0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] fword(input int w);
    return {rxf[4*w+3], rxf[4*w+2], rxf[4*w+1], rxf[4*w]};
  endfunction

  int cmd_cyc = 0;
  // Called at a negedge; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    dbg.i_rx_data = b;
    dbg.i_rx_done = 1'b1;
    cmd_cyc = cyc;
    @(negedge i_clk);
    dbg.i_rx_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (dbg.o_busy && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("dump_timeout", {31'd0, dbg.o_busy}, 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_start"}, {31'd0, dbg.o_tx_start}, 32'd0);
    chk({tag, "_tx_data"},  {24'd0, dbg.o_tx_data}, 32'd0);
    chk({tag, "_step"},     {31'd0, dbg.o_step}, 32'd0);
    chk({tag, "_regnum"},   {27'd0, dbg.o_debug_mips_register_number}, 32'd0);
    chk({tag, "_addr"},     dbg.o_debug_address, 32'd0);
    chk({tag, "_busy"},     {31'd0, dbg.o_busy}, 32'd0);
  endtask

  logic [31:0] exp_pcs [8] = '{32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd8};

  initial begin
    int s0, f0, n;
    logic [31:0] pc_pause;
    for (int r = 0; r < 32; r++) regs[r] = 32'h1000_0000 + r * 32'h0101_0101;
    for (int m = 0; m < TAM; m++) mem[m] = 32'hA000_0000 ^ (m * 32'h0007_0013);
    regs[5] = 32'hDEADBEEF;
    mem[3]  = 32'h12345678;
    dbg.i_rx_data = '0;
    dbg.i_rx_done = 1'b0;

    // Reset state
    #1 i_reset = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Single step after reset: one step pulse, full frame, PC=4, latency 4
    s0 = step_cnt; f0 = frames_done;
    send_byte(8'h53);
    wait_idle(3000);
    chk("s_step_pulses", 32'(step_cnt - s0), 32'd1);
    chk("s_frames", 32'(frames_done - f0), 32'd1);
    chk("s_frame_len", 32'(frame_pos), 32'd0);
    chk("s_byte0", {24'd0, rxf[0]}, 32'h04);
    chk("s_byte1", {24'd0, rxf[1]}, 32'h00);
    chk("s_byte2", {24'd0, rxf[2]}, 32'h00);
    chk("s_byte3", {24'd0, rxf[3]}, 32'h00);
    chk("s_latency", 32'(first_tx_cyc - cmd_cyc), 32'd4);
    chk("s_end_regnum", {27'd0, dbg.o_debug_mips_register_number}, 32'd0);
    chk("s_end_addr", dbg.o_debug_address, 32'd0);

    // Eight more steps through the jump
    for (int k = 0; k < 8; k++) begin
      send_byte(8'h53);
      wait_idle(3000);
      chk("step_pc", fword(0), exp_pcs[k]);
    end

    // Dump: register and memory words land in the right slots
    send_byte(8'h44);
    wait_idle(3000);
    chk("d_r5_word", fword(7), 32'hDEADBEEF);
    chk("d_byte28", {24'd0, rxf[28]}, 32'hEF);
    chk("d_mem3_word", fword(37), 32'h12345678);
    chk("d_byte148", {24'd0, rxf[148]}, 32'h78);
    for (int i = 148; i < 152; i++) chk("d_mem3_addr", addr_at[i], 32'd12);

    // Commands during a dump are dropped
    s0 = step_cnt; f0 = frames_done;
    send_byte(8'h44);
    repeat (20) @(negedge i_clk);
    send_byte(8'h41);
    repeat (5) @(negedge i_clk);
    send_byte(8'h53);
    wait_idle(3000);
    repeat (30) @(negedge i_clk);
    chk("busy_frames", 32'(frames_done - f0), 32'd1);
    chk("busy_steps", 32'(step_cnt - s0), 32'd0);
    chk("busy_idle", {31'd0, dbg.o_busy}, 32'd0);

    // Continuous run, then pause
    s0 = step_cnt; f0 = frames_done;
    send_byte(8'h43);
    repeat (10) @(negedge i_clk);
    send_byte(8'h50);
    pc_pause = pc_r;
    wait_idle(3000);
    chk("run_steps", 32'(step_cnt - s0), 32'd11);
    chk("run_frames", 32'(frames_done - f0), 32'd1);
    chk("run_pc_pause", pc_pause, 32'd24);
    chk("run_frame_pc", fword(0), pc_pause);

    // Reset mid-frame after byte 57, then a clean dump from byte 0
    send_byte(8'h44);
    n = 0;
    while (frame_pos != 58 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    chk("mid_reached", 32'(frame_pos), 32'd58);
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1 chk_outputs_zero("midreset");
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("post_reset_idle", {31'd0, dbg.o_busy}, 32'd0);
    f0 = frames_done;
    send_byte(8'h44);
    wait_idle(3000);
    chk("restart_frames", 32'(frames_done - f0), 32'd1);
    chk("restart_pc", fword(0), 32'd0);
    chk("restart_alu", fword(1), 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
